// File: rtl/mul_prog_pkg.sv
// Shared types and helpers for the precision-selectable iterative multiplier.
// Saturation of the -1.0 x -1.0 product is enabled by MUL_PROG_SAT_EN.
package mul_prog_pkg;

  typedef enum logic [1:0] {
    PREC_QTR  = 2'd0,
    PREC_HALF = 2'd1,
    PREC_FULL = 2'd2
  } prec_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int prec_bits(prec_e p, int w);
    case (p)
      PREC_QTR:  return w / 4;
      PREC_HALF: return w / 2;
      default:   return w;
    endcase
  endfunction

endpackage

// File: rtl/mul_prog_if.sv
// Valid/ready operand and result bundle for mul_prog_seq.
// The slave side is the multiplier, the master side its client.
interface mul_prog_if #(
  parameter int W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     prec;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_data;
  logic [1:0]     out_prec;
  logic           busy;
  logic           sat;

  modport master (
    output in_valid, a, b, prec, out_ready,
    input  in_ready, out_valid, out_data, out_prec, busy, sat
  );

  modport slave (
    input  in_valid, a, b, prec, out_ready,
    output in_ready, out_valid, out_data, out_prec, busy, sat
  );
endinterface

// File: rtl/mul_prog_seq_pp.sv
// One radix-2^R iteration: sum of R shifted partial products.
// The top multiplier bit carries negative weight on the last iteration.
module mul_prog_pp_step #(
  parameter int W = 16,
  parameter int R = 2
) (
  input  logic signed [2*W-1:0]     a_i,
  input  logic        [R-1:0]       bits_i,
  input  logic        [$clog2(W)-1:0] off_i,
  input  logic                      last_i,
  output logic signed [2*W-1:0]     sum_o
);

  always_comb begin
    sum_o = '0;
    for (int k = 0; k < R; k++) begin
      if (bits_i[k]) begin
        if (last_i && (k == R - 1))
          sum_o = sum_o - (a_i << (int'(off_i) + k));
        else
          sum_o = sum_o + (a_i << (int'(off_i) + k));
      end
    end
  end

endmodule

// File: rtl/mul_prog_seq.sv
// Iterative signed Q0.(W-1) multiplier, R bits per clock, P = W/4, W/2 or W.
// Optional MUL_PROG_SAT_EN clamps the +1.0 product to the largest value at P.
module mul_prog_seq
  import mul_prog_pkg::*;
#(
  parameter int W = 16,
  parameter int R = 2
) (
  input logic      clk,
  input logic      rst_n,
  mul_prog_if.slave io
);

  localparam int AW = 2 * W;
  localparam int CW = $clog2(W / R);
  localparam int OW = $clog2(W);
  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] MAXP = ONE << (AW - 2);

  state_e                state_q;
  prec_e                 prec_q;
  prec_e                 out_prec_q;
  prec_e                 pe;
  logic signed [AW-1:0]  a_q;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW-1:0]  acc_d;
  logic signed [AW-1:0]  step;
  logic signed [AW-1:0]  a_ext;
  logic signed [AW-1:0]  a_t;
  logic        [W-1:0]   b_q;
  logic        [W-1:0]   b_t;
  logic        [CW-1:0]  cnt_q;
  logic        [CW-1:0]  idx_q;
  logic        [CW-1:0]  cnt_init;
  logic        [OW-1:0]  off;
  logic        [AW-1:0]  res_d;
  logic        [AW-1:0]  out_data_q;
  logic                  sat_d;
  logic                  sat_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic                  in_rdy;
  int                    p_in;
  int                    p_q;
  int                    sh;

  // Mode 3 is folded onto full precision.
  assign pe       = (io.prec == 2'd3) ? PREC_FULL : prec_e'(io.prec);
  assign p_in     = prec_bits(pe, W);
  assign a_ext    = {{W{io.a[W-1]}}, io.a};
  assign a_t      = a_ext >>> (W - p_in);
  assign b_t      = io.b >> (W - p_in);
  assign cnt_init = CW'(p_in / R - 1);

  assign p_q   = prec_bits(prec_q, W);
  assign sh    = 2 * (W - p_q);
  assign off   = OW'(int'(idx_q) * R);
  assign acc_d = acc_q + step;

  mul_prog_pp_step #(
    .W (W),
    .R (R)
  ) u_pp (
    .a_i    (a_q),
    .bits_i (b_q[R-1:0]),
    .off_i  (off),
    .last_i (cnt_q == '0),
    .sum_o  (step)
  );

`ifdef MUL_PROG_SAT_EN
  assign sat_d = (acc_d == (ONE << (2 * p_q - 2)));
  assign res_d = sat_d ? (MAXP - (ONE << sh)) : (acc_d << sh);
`else
  assign sat_d = 1'b0;
  assign res_d = acc_d << sh;
`endif

  assign in_rdy = (state_q == IDLE) || ((state_q == DONE) && io.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prec_q      <= PREC_QTR;
      out_prec_q  <= PREC_QTR;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (io.in_valid && in_rdy) begin
            a_q         <= a_t;
            b_q         <= b_t;
            prec_q      <= pe;
            acc_q       <= '0;
            cnt_q       <= cnt_init;
            idx_q       <= '0;
            state_q     <= RUN;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
          end else if ((state_q == DONE) && io.out_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          b_q   <= b_q >> R;
          cnt_q <= cnt_q - 1'b1;
          idx_q <= idx_q + 1'b1;
          if (cnt_q == '0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_data_q  <= res_d;
            out_prec_q  <= prec_q;
            sat_q       <= sat_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_rdy;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = out_data_q;
  assign io.out_prec  = out_prec_q;
  assign io.busy      = busy_q;
  assign io.sat       = sat_q;

endmodule

// File: tb/tb_mul_prog_seq.sv
// Directed and randomised checks of mul_prog_seq at W=16, R=2.
// Expectations track MUL_PROG_SAT_EN when it is defined.
module tb_mul_prog_seq;

  localparam int W = 16;
  localparam int R = 2;
`ifdef MUL_PROG_SAT_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  prec;
    logic [31:0] data;
    logic [1:0]  oprec;
    int          lat;
    logic        sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_prog_if #(.W(W)) bus ();

  mul_prog_seq #(
    .W (W),
    .R (R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] p);
    int     pb;
    int     at;
    int     bt;
    longint prod;
    pb   = (p == 2'd0) ? 4 : (p == 2'd1) ? 8 : 16;
    at   = $signed(a) >>> (16 - pb);
    bt   = $signed(b) >>> (16 - pb);
    prod = longint'(at) * longint'(bt);
    if (SAT_ON && at == -(1 <<< (pb - 1)) && bt == at)
      return {1'b1, 32'h4000_0000 - (32'h1 << (2 * (16 - pb)))};
    return {1'b0, 32'(prod <<< (2 * (16 - pb)))};
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) break;
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] p);
    int n;
    bus.a = a; bus.b = b; bus.prec = p; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic retire(input int stall);
    bus.out_ready = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("retire", {63'd0, bus.out_valid}, 64'd0);
  endtask

  task automatic check_op(input string nm, input vec_t v, input int lat);
    chk({nm, ".lat"},  64'(lat), 64'(v.lat));
    chk({nm, ".data"}, {32'd0, bus.out_data}, {32'd0, v.data});
    chk({nm, ".prec"}, {62'd0, bus.out_prec}, {62'd0, v.oprec});
    chk({nm, ".sat"},  {63'd0, bus.sat}, {63'd0, v.sat});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    vec_t v;
    int   lat;
    bit   seen;
    logic [32:0] m;

    tbl[0]  = '{16'h4000, 16'h4000, 2'd2, 32'h1000_0000, 2'd2, 8, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h7FFF, 2'd1, 32'h3F01_0000, 2'd1, 4, 1'b0};
    tbl[2]  = '{16'hC000, 16'h4000, 2'd0, 32'hF000_0000, 2'd0, 2, 1'b0};
    tbl[3]  = '{16'h8000, 16'h8000, 2'd2,
                SAT_ON ? 32'h3FFF_FFFF : 32'h4000_0000, 2'd2, 8, SAT_ON};
    tbl[4]  = '{16'h4000, 16'hC000, 2'd3, 32'hF000_0000, 2'd2, 8, 1'b0};
    tbl[5]  = '{16'h8000, 16'h8000, 2'd0,
                SAT_ON ? 32'h3F00_0000 : 32'h4000_0000, 2'd0, 2, SAT_ON};
    tbl[6]  = '{16'h1234, 16'h0000, 2'd2, 32'h0000_0000, 2'd2, 8, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'hFFFF, 2'd2, 32'h0000_0001, 2'd2, 8, 1'b0};
    tbl[8]  = '{16'h7FFF, 16'h8000, 2'd2, 32'hC000_8000, 2'd2, 8, 1'b0};
    tbl[9]  = '{16'h1234, 16'h5678, 2'd1, 32'h060C_0000, 2'd1, 4, 1'b0};
    tbl[10] = '{16'hA5F0, 16'h3C00, 2'd0, 32'hEE00_0000, 2'd0, 2, 1'b0};
    tbl[11] = '{16'h8000, 16'h7FFF, 2'd1, 32'hC080_0000, 2'd1, 4, 1'b0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.prec = '0;
    #12;
    chk("reset", {bus.out_valid, bus.in_ready, bus.busy, bus.sat, bus.out_prec, bus.out_data},
        {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].prec);
      wait_done(lat);
      check_op($sformatf("vec%0d", i), tbl[i], lat);
      retire(i % 3);
    end

    // Stall in DONE, then retire and accept on the same edge.
    issue(16'h1234, 16'h5678, 2'd1);
    wait_done(lat);
    check_op("stall", tbl[9], lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d", i), {bus.out_valid, bus.in_ready, bus.out_data},
          {1'b1, 1'b0, 32'h060C_0000});
    end
    bus.a = 16'h7FFF; bus.b = 16'h7FFF; bus.prec = 2'd1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    chk("b2b.ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("b2b.run", {62'd0, bus.busy, bus.out_valid}, {62'd0, 1'b1, 1'b0});
    wait_done(lat);
    check_op("b2b", tbl[1], lat);
    retire(0);

    // Asynchronous reset in the middle of RUN.
    issue(16'h4000, 16'h4000, 2'd2);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_run", {bus.out_valid, bus.in_ready, bus.busy, bus.sat, bus.out_prec, bus.out_data},
        {1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0});
    #3 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("rst_novalid", {63'd0, seen}, 64'd0);

    // Randomised operands and stalls against the reference product.
    for (int i = 0; i < 300; i++) begin
      v.a    = 16'($urandom);
      v.b    = 16'($urandom);
      v.prec = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        v.a = 16'h8000; v.b = 16'h8000;
      end
      m       = model(v.a, v.b, v.prec);
      v.data  = m[31:0];
      v.sat   = m[32];
      v.oprec = (v.prec == 2'd3) ? 2'd2 : v.prec;
      v.lat   = (v.prec == 2'd0) ? 2 : (v.prec == 2'd1) ? 4 : 8;
      issue(v.a, v.b, v.prec);
      wait_done(lat);
      check_op($sformatf("rnd%0d", i), v, lat);
      retire($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
